mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port main-memory arbiter and burst sequencer shared by ICache refill, DCache refill and DCache dirty-line writeback.
- Sits between the cache memory-side handshakes (valid/ready, line-wide data) and one word-wide memory bus.
- Splits each cache-line transfer into sequential word beats and assembles read lines.
- Grants one requester at a time; data side fixed priority; a D writeback/refill pair is never interleaved with an I refill.

Parameters:
ADDR_W, 32, address width (= `WORD)
WORD_W, 32, memory bus data width (= `WORD)
LINE_W, 128, cache line width (= `CACHE_LINE_WIDTH); BEATS = LINE_W/WORD_W, power of two, >=2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
icache_rd_req  in  1  ICache line-refill request (level)
icache_rd_addr  in  ADDR_W  ICache refill address
icache_rd_ready  out  1  one-cycle pulse: icache_rd_data valid
icache_rd_data  out  LINE_W  refilled line
dcache_rd_req  in  1  DCache refill request (level)
dcache_rd_addr  in  ADDR_W  DCache refill address
dcache_rd_ready  out  1  one-cycle pulse: dcache_rd_data valid
dcache_rd_data  out  LINE_W  refilled line
dcache_wr_req  in  1  DCache writeback request (level)
dcache_wr_addr  in  ADDR_W  writeback address
dcache_wr_data  in  LINE_W  dirty line
dcache_wr_done  out  1  one-cycle pulse: writeback complete
mem_req  out  1  memory beat request
mem_we  out  1  1 = write beat
mem_addr  out  ADDR_W  beat word address
mem_wdata  out  WORD_W  write data
mem_ack  in  1  beat accepted/completed this cycle (rdata valid if read)
mem_rdata  in  WORD_W  read data

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, line buffer 0, all outputs 0. Any in-flight burst is abandoned; the memory model must tolerate mem_req dropping.
- Requester rule: hold req/addr/wdata stable until its ready/done pulse; deassert req at the clock edge where the pulse is sampled. Req withdrawn mid-burst: burst still completes and the pulse is still issued.
- FSM states: IDLE, D_WR, D_RD, I_RD, RESP.
- IDLE arbitration priority: dcache_wr_req > dcache_rd_req > icache_rd_req.
  - On grant, latch base = addr with low log2(LINE_W/8) bits cleared.
  - For D_WR, also latch dcache_wr_data.
  - Beat counter = 0.
  - Grant takes effect the next cycle; no memory beat is issued in IDLE.
- Burst states (D_WR, D_RD, I_RD):
  - mem_req=1; mem_addr = base + 4*beat; mem_we=1 only in D_WR; mem_wdata = latched line[beat*WORD_W +: WORD_W].
  - On mem_ack: read beat stores mem_rdata into buffer[beat*WORD_W +: WORD_W]; beat increments; mem_req stays high for back-to-back beats.
  - Without ack: all outputs hold.
- Last beat acked (beat = BEATS-1):
  - D_WR: if dcache_rd_req is high, go directly to D_RD with the new base latched. This skips IDLE so a pending I request cannot intervene. Otherwise go to RESP.
  - Reads: go to RESP.
- RESP (1 cycle): pulse the matching ready/done; mem_req=0; go to IDLE.
  - Read data outputs hold the assembled line from RESP until the next grant of the same port.
  - For a D_WR chained into D_RD, dcache_wr_done pulses in the first D_RD cycle.
- Minimum latency, ack every cycle, read: grant edge + BEATS beat cycles + 1 RESP cycle. Pulse in cycle BEATS+2 after req is first seen in IDLE.
- Simultaneous requests in IDLE: priority order above. ICache may starve only while DCache requests persist; bounded because the pipeline stalls during D misses.
- Address overflow: base + 4*beat wraps modulo 2^ADDR_W.

Decomposition:
- Shared package/header: WORD, CACHE_LINE_WIDTH (already in CPU_Parameter.vh); add BEATS and MEM_ARB state encodings.
- One sub-module: mem_line_buffer. It holds the beat counter, last-beat flag, read-line assembly register and write-line word select, driven by load/ack/clear from the FSM.

Test Plan:
- I refill, icache_rd_addr=0x1C000014, memory returns 0x11,0x22,0x33,0x44 with ack every cycle -> mem_addr 0x1C000010/14/18/1C; icache_rd_ready pulses once in cycle 6; icache_rd_data=0x00000044_00000033_00000022_00000011.
- D refill and I refill raised the same cycle -> D burst first, then I burst; dcache_rd_ready pulses before any I beat; I line correct.
- Dirty eviction: dcache_wr_req (addr 0x100, line 0xDDDD_CCCC_BBBB_AAAA words) and dcache_rd_req (0x200) together, plus icache_rd_req -> write beats 0x100..0x10C with mem_we=1 and the correct words; then read beats 0x200.. with no IDLE gap; wr_done then rd_ready; I served last.
- Random mem_ack stalls (0-3 cycles per beat) -> mem_addr/mem_wdata/mem_we stable while unacked; line assembled correctly.
- rst low during beat 2 of a D refill -> all outputs 0 immediately (async); after release, reissued request completes a full 4-beat burst from beat 0.
- icache_rd_req dropped mid-burst -> burst finishes; icache_rd_ready still pulses once; FSM returns to IDLE with no extra beats.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, beat count and state encoding for the memory arbiter and its line buffer.
package mem_arbiter_pkg;

    localparam int WORD             = 32;
    localparam int CACHE_LINE_WIDTH = 128;
    localparam int BEATS            = CACHE_LINE_WIDTH / WORD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_D_WR = 3'd1,
        ST_D_RD = 3'd2,
        ST_I_RD = 3'd3,
        ST_RESP = 3'd4
    } arb_state_t;

    function automatic logic is_burst(input arb_state_t s);
        return (s == ST_D_WR) || (s == ST_D_RD) || (s == ST_I_RD);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request handshakes and the word-wide memory bus of the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = WORD,
    parameter int WORD_W = WORD,
    parameter int LINE_W = CACHE_LINE_WIDTH
);
    logic              icache_rd_req;
    logic [ADDR_W-1:0] icache_rd_addr;
    logic              icache_rd_ready;
    logic [LINE_W-1:0] icache_rd_data;

    logic              dcache_rd_req;
    logic [ADDR_W-1:0] dcache_rd_addr;
    logic              dcache_rd_ready;
    logic [LINE_W-1:0] dcache_rd_data;

    logic              dcache_wr_req;
    logic [ADDR_W-1:0] dcache_wr_addr;
    logic [LINE_W-1:0] dcache_wr_data;
    logic              dcache_wr_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    // Arbiter side: serves the caches, masters the memory bus.
    modport slave (
        input  icache_rd_req, icache_rd_addr,
        output icache_rd_ready, icache_rd_data,
        input  dcache_rd_req, dcache_rd_addr,
        output dcache_rd_ready, dcache_rd_data,
        input  dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        output dcache_wr_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output icache_rd_req, icache_rd_addr,
        input  icache_rd_ready, icache_rd_data,
        output dcache_rd_req, dcache_rd_addr,
        input  dcache_rd_ready, dcache_rd_data,
        output dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        input  dcache_wr_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_line_buffer.sv
// Beat counter plus one line register used as write source or read assembly target.
module mem_line_buffer
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_W = WORD,
    parameter int LINE_W = CACHE_LINE_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [LINE_W-1:0]                 load_line,
    input  logic                              ack,
    input  logic                              capture,
    input  logic [WORD_W-1:0]                 rdata,
    output logic [$clog2(LINE_W/WORD_W)-1:0]  beat,
    output logic                              last,
    output logic [WORD_W-1:0]                 wr_word,
    output logic [LINE_W-1:0]                 line_next
);
    localparam int NBEATS = LINE_W / WORD_W;
    localparam int BEAT_W = $clog2(NBEATS);

    logic [LINE_W-1:0] line_q;

    // Load wins over ack so a chained grant on the final beat restarts at beat 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat   <= '0;
            line_q <= '0;
        end else if (load) begin
            beat   <= '0;
            line_q <= load_line;
        end else if (ack) begin
            beat <= beat + 1'b1;
            if (capture) begin
                line_q[beat*WORD_W +: WORD_W] <= rdata;
            end
        end
    end

    assign last    = (beat == BEAT_W'(NBEATS - 1));
    assign wr_word = line_q[beat*WORD_W +: WORD_W];

    // Line as it will look once the word on the bus this cycle is stored.
    always_comb begin
        line_next = line_q;
        line_next[beat*WORD_W +: WORD_W] = rdata;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I refill, D refill and D writeback onto one memory port as sequential word bursts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no burst; pick highest-priority request, latch its base
// D_WR    | DCache writeback beats (mem_we=1)
// D_RD    | DCache refill beats
// I_RD    | ICache refill beats
// RESP    | one idle cycle carrying the ready/done pulse
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = WORD,
    parameter int WORD_W = WORD,
    parameter int LINE_W = CACHE_LINE_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int NBEATS     = LINE_W / WORD_W;
    localparam int BEAT_W     = $clog2(NBEATS);
    localparam int BYTE_SHIFT = $clog2(WORD_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_W / 8 - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              load;
    logic [LINE_W-1:0] load_line;
    logic              fin_wr, fin_drd, fin_ird;

    logic              burst;
    logic              burst_ack;
    logic              capture;
    logic [BEAT_W-1:0] beat;
    logic              last;
    logic [WORD_W-1:0] wr_word;
    logic [LINE_W-1:0] line_next;

    logic              icache_rd_ready_q, dcache_rd_ready_q, dcache_wr_done_q;
    logic [LINE_W-1:0] icache_line_q, dcache_line_q;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~LINE_MASK;
    endfunction

    assign burst     = is_burst(state_q);
    assign burst_ack = burst && bus.mem_ack;
    assign capture   = (state_q == ST_D_RD) || (state_q == ST_I_RD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        load      = 1'b0;
        load_line = '0;
        fin_wr    = 1'b0;
        fin_drd   = 1'b0;
        fin_ird   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dcache_wr_req) begin
                    state_d   = ST_D_WR;
                    base_d    = line_base(bus.dcache_wr_addr);
                    load      = 1'b1;
                    load_line = bus.dcache_wr_data;
                end else if (bus.dcache_rd_req) begin
                    state_d = ST_D_RD;
                    base_d  = line_base(bus.dcache_rd_addr);
                    load    = 1'b1;
                end else if (bus.icache_rd_req) begin
                    state_d = ST_I_RD;
                    base_d  = line_base(bus.icache_rd_addr);
                    load    = 1'b1;
                end
            end
            ST_D_WR: begin
                if (bus.mem_ack && last) begin
                    fin_wr = 1'b1;
                    // Chain straight into the refill so an I request cannot slip in between.
                    if (bus.dcache_rd_req) begin
                        state_d = ST_D_RD;
                        base_d  = line_base(bus.dcache_rd_addr);
                        load    = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_D_RD: begin
                if (bus.mem_ack && last) begin
                    fin_drd = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_I_RD: begin
                if (bus.mem_ack && last) begin
                    fin_ird = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    mem_line_buffer #(
        .WORD_W (WORD_W),
        .LINE_W (LINE_W)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_line (load_line),
        .ack       (burst_ack),
        .capture   (capture),
        .rdata     (bus.mem_rdata),
        .beat      (beat),
        .last      (last),
        .wr_word   (wr_word),
        .line_next (line_next)
    );

    // Pulses land in the cycle after the final ack: RESP, or the first D_RD cycle when chained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            icache_rd_ready_q <= 1'b0;
            dcache_rd_ready_q <= 1'b0;
            dcache_wr_done_q  <= 1'b0;
            icache_line_q     <= '0;
            dcache_line_q     <= '0;
        end else begin
            icache_rd_ready_q <= fin_ird;
            dcache_rd_ready_q <= fin_drd;
            dcache_wr_done_q  <= fin_wr;
            if (fin_ird) begin
                icache_line_q <= line_next;
            end
            if (fin_drd) begin
                dcache_line_q <= line_next;
            end
        end
    end

    assign bus.icache_rd_ready = icache_rd_ready_q;
    assign bus.icache_rd_data  = icache_line_q;
    assign bus.dcache_rd_ready = dcache_rd_ready_q;
    assign bus.dcache_rd_data  = dcache_line_q;
    assign bus.dcache_wr_done  = dcache_wr_done_q;

    assign bus.mem_req   = burst;
    assign bus.mem_we    = (state_q == ST_D_WR);
    assign bus.mem_addr  = burst ? base_q + (ADDR_W'(beat) << BYTE_SHIFT) : '0;
    assign bus.mem_wdata = (state_q == ST_D_WR) ? wr_word : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: memory model with random stalls, reference beat/line model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int stall_max = 0;
    int wait_left = -1;
    int stall_viol = 0;
    int wr_cnt, drd_cnt, ird_cnt;
    int wr_cyc, drd_cyc, ird_cyc;
    logic [127:0] drd_line, ird_line;
    logic        prev_pend = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    beat_t beats[$];
    beat_t exp_beats[$];
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] a);
        logic [127:0] l;
        logic [31:0]  b;
        b = a & ~32'(BEATS * 4 - 1);
        for (int k = 0; k < BEATS; k++) l[32*k +: 32] = mem_val(b + 32'(4 * k));
        return l;
    endfunction

    // Requests raised together are served strictly wr, then rd, then I; each is BEATS sequential words.
    function automatic void build_model(input bit w, input bit dr, input bit ir,
                                        input logic [31:0] wa, input logic [31:0] da,
                                        input logic [31:0] ia, input logic [127:0] wl);
        logic [31:0] b;
        exp_beats.delete();
        if (w) begin
            b = wa & ~32'(BEATS * 4 - 1);
            for (int k = 0; k < BEATS; k++) exp_beats.push_back('{1'b1, b + 32'(4 * k), wl[32*k +: 32], 0});
        end
        if (dr) begin
            b = da & ~32'(BEATS * 4 - 1);
            for (int k = 0; k < BEATS; k++) exp_beats.push_back('{1'b0, b + 32'(4 * k), 32'h0, 0});
        end
        if (ir) begin
            b = ia & ~32'(BEATS * 4 - 1);
            for (int k = 0; k < BEATS; k++) exp_beats.push_back('{1'b0, b + 32'(4 * k), 32'h0, 0});
        end
    endfunction

    // Memory model and observer: decides ack mid-cycle, logs completed beats and pulses.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            wait_left     = -1;
            prev_pend     = 1'b0;
        end else begin
            if (prev_pend && bus.mem_req &&
                (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we || bus.mem_wdata !== prev_wdata))
                stall_viol++;
            if (bus.mem_req) begin
                if (wait_left < 0) wait_left = int'($urandom_range(0, stall_max));
                bus.mem_rdata = mem_val(bus.mem_addr);
                if (wait_left == 0) begin
                    bus.mem_ack = 1'b1;
                    wait_left   = -1;
                    beats.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata, cyc});
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
                wait_left     = -1;
            end
            prev_pend  = bus.mem_req && !bus.mem_ack;
            prev_addr  = bus.mem_addr;
            prev_we    = bus.mem_we;
            prev_wdata = bus.mem_wdata;
            if (bus.dcache_wr_done)  begin wr_cnt++;  wr_cyc  = cyc; end
            if (bus.dcache_rd_ready) begin drd_cnt++; drd_cyc = cyc; drd_line = bus.dcache_rd_data; end
            if (bus.icache_rd_ready) begin ird_cnt++; ird_cyc = cyc; ird_line = bus.icache_rd_data; end
        end
    end

    task automatic run_scn(input bit w, input bit dr, input bit ir,
                           input logic [31:0] wa, input logic [31:0] da, input logic [31:0] ia,
                           input logic [127:0] wl, input int stall, input int drop_i_after,
                           output bit to);
        int n;
        beats.delete();
        wr_cnt = 0; drd_cnt = 0; ird_cnt = 0;
        wr_cyc = 0; drd_cyc = 0; ird_cyc = 0;
        stall_viol = 0;
        stall_max  = stall;
        @(posedge clk); #2;
        bus.dcache_wr_addr = wa; bus.dcache_wr_data = wl;
        bus.dcache_rd_addr = da; bus.icache_rd_addr = ia;
        bus.dcache_wr_req = w; bus.dcache_rd_req = dr; bus.icache_rd_req = ir;
        start_cyc = cyc + 1;
        n = 0;
        while (!((!w || wr_cnt > 0) && (!dr || drd_cnt > 0) && (!ir || ird_cnt > 0)) && n < 600) begin
            @(negedge clk); #1;
            if (wr_cnt > 0)  bus.dcache_wr_req = 1'b0;
            if (drd_cnt > 0) bus.dcache_rd_req = 1'b0;
            if (ird_cnt > 0) bus.icache_rd_req = 1'b0;
            if (drop_i_after >= 0 && beats.size() >= drop_i_after) bus.icache_rd_req = 1'b0;
            n++;
        end
        to = (n >= 600);
        bus.dcache_wr_req = 1'b0; bus.dcache_rd_req = 1'b0; bus.icache_rd_req = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_we_wdata got %b/%h want 0/0", bus.mem_we, bus.mem_wdata); end
        checks++; if ({bus.icache_rd_ready, bus.dcache_rd_ready, bus.dcache_wr_done} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {bus.icache_rd_ready, bus.dcache_rd_ready, bus.dcache_wr_done}); end
        checks++; if (bus.icache_rd_data !== 128'h0 || bus.dcache_rd_data !== 128'h0) begin errors++; $display("FAIL rst_lines got %h/%h want 0", bus.icache_rd_data, bus.dcache_rd_data); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL idle_mem_req got %b want 0", bus.mem_req); end
    endtask

    task automatic test_i_refill();
        bit to;
        mem_img[32'h1C000010] = 32'h11; mem_img[32'h1C000014] = 32'h22;
        mem_img[32'h1C000018] = 32'h33; mem_img[32'h1C00001C] = 32'h44;
        build_model(0, 0, 1, 0, 0, 32'h1C000014, 0);
        run_scn(0, 0, 1, 0, 0, 32'h1C000014, 0, 0, -1, to);
        checks++; if (to) begin errors++; $display("FAIL ifill_timeout got 1 want 0"); end
        checks++; if (beats.size() != BEATS) begin errors++; $display("FAIL ifill_nbeats got %0d want %0d", beats.size(), BEATS); end
        for (int k = 0; k < BEATS && k < beats.size(); k++) begin
            checks++; if (beats[k].addr !== exp_beats[k].addr || beats[k].we !== 1'b0) begin errors++; $display("FAIL ifill_beat%0d got %h/%b want %h/0", k, beats[k].addr, beats[k].we, exp_beats[k].addr); end
        end
        checks++; if (ird_cyc - start_cyc + 1 != 6) begin errors++; $display("FAIL ifill_latency got cycle %0d want 6", ird_cyc - start_cyc + 1); end
        checks++; if (ird_cnt != 1) begin errors++; $display("FAIL ifill_pulses got %0d want 1", ird_cnt); end
        checks++; if (ird_line !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL ifill_line got %h want 00000044000000330000002200000011", ird_line); end
    endtask

    task automatic test_priority();
        bit to;
        logic [31:0] da, ia;
        da = $urandom; ia = $urandom;
        build_model(0, 1, 1, 0, da, ia, 0);
        run_scn(0, 1, 1, 0, da, ia, 0, 0, -1, to);
        checks++; if (to || beats.size() != 2 * BEATS) begin errors++; $display("FAIL prio_nbeats got %0d to=%b want %0d", beats.size(), to, 2 * BEATS); end
        for (int k = 0; k < 2 * BEATS && k < beats.size(); k++) begin
            checks++; if (beats[k].addr !== exp_beats[k].addr) begin errors++; $display("FAIL prio_beat%0d got %h want %h", k, beats[k].addr, exp_beats[k].addr); end
        end
        if (beats.size() > BEATS) begin
            checks++; if (drd_cyc >= beats[BEATS].cyc) begin errors++; $display("FAIL prio_order got drd %0d first_i %0d want drd earlier", drd_cyc, beats[BEATS].cyc); end
        end
        checks++; if (drd_line !== exp_line(da) || ird_line !== exp_line(ia)) begin errors++; $display("FAIL prio_lines got %h/%h want %h/%h", drd_line, ird_line, exp_line(da), exp_line(ia)); end
    endtask

    task automatic test_eviction();
        bit to;
        logic [31:0]  ia;
        logic [127:0] wl;
        ia = $urandom;
        wl = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        build_model(1, 1, 1, 32'h100, 32'h200, ia, wl);
        run_scn(1, 1, 1, 32'h100, 32'h200, ia, wl, 0, -1, to);
        checks++; if (to || beats.size() != 3 * BEATS) begin errors++; $display("FAIL evict_nbeats got %0d to=%b want %0d", beats.size(), to, 3 * BEATS); end
        for (int k = 0; k < 3 * BEATS && k < beats.size(); k++) begin
            checks++;
            if (beats[k].addr !== exp_beats[k].addr || beats[k].we !== exp_beats[k].we ||
                (exp_beats[k].we && beats[k].wdata !== exp_beats[k].wdata)) begin
                errors++; $display("FAIL evict_beat%0d got %h/%b/%h want %h/%b/%h", k, beats[k].addr, beats[k].we, beats[k].wdata, exp_beats[k].addr, exp_beats[k].we, exp_beats[k].wdata);
            end
        end
        if (beats.size() > BEATS) begin
            checks++; if (beats[BEATS].cyc != beats[BEATS-1].cyc + 1) begin errors++; $display("FAIL evict_gap got %0d want %0d", beats[BEATS].cyc, beats[BEATS-1].cyc + 1); end
            checks++; if (wr_cyc != beats[BEATS].cyc) begin errors++; $display("FAIL evict_done_cycle got %0d want %0d", wr_cyc, beats[BEATS].cyc); end
        end
        checks++; if (!(wr_cyc < drd_cyc && drd_cyc < ird_cyc)) begin errors++; $display("FAIL evict_order got %0d/%0d/%0d want ascending", wr_cyc, drd_cyc, ird_cyc); end
        checks++; if (drd_line !== exp_line(32'h200) || ird_line !== exp_line(ia)) begin errors++; $display("FAIL evict_lines got %h/%h want %h/%h", drd_line, ird_line, exp_line(32'h200), exp_line(ia)); end
    endtask

    task automatic test_random_stalls();
        bit to, w, dr, ir;
        logic [31:0]  wa, da, ia;
        logic [127:0] wl;
        for (int it = 0; it < 25; it++) begin
            do begin w = 1'($urandom); dr = 1'($urandom); ir = 1'($urandom); end while (!(w || dr || ir));
            wa = $urandom; da = (it % 5 == 0) ? 32'hFFFFFFF8 : $urandom; ia = $urandom;
            wl = {$urandom, $urandom, $urandom, $urandom};
            build_model(w, dr, ir, wa, da, ia, wl);
            run_scn(w, dr, ir, wa, da, ia, wl, 3, -1, to);
            checks++; if (to || beats.size() != exp_beats.size()) begin errors++; $display("FAIL rand%0d_nbeats got %0d to=%b want %0d", it, beats.size(), to, exp_beats.size()); end
            for (int k = 0; k < exp_beats.size() && k < beats.size(); k++) begin
                checks++;
                if (beats[k].addr !== exp_beats[k].addr || beats[k].we !== exp_beats[k].we ||
                    (exp_beats[k].we && beats[k].wdata !== exp_beats[k].wdata)) begin
                    errors++; $display("FAIL rand%0d_beat%0d got %h/%b/%h want %h/%b/%h", it, k, beats[k].addr, beats[k].we, beats[k].wdata, exp_beats[k].addr, exp_beats[k].we, exp_beats[k].wdata);
                end
            end
            checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_stall_hold got %0d changes want 0", it, stall_viol); end
            checks++; if (wr_cnt != int'(w) || drd_cnt != int'(dr) || ird_cnt != int'(ir)) begin errors++; $display("FAIL rand%0d_pulses got %0d%0d%0d want %0d%0d%0d", it, wr_cnt, drd_cnt, ird_cnt, w, dr, ir); end
            if (dr) begin
                checks++; if (drd_line !== exp_line(da)) begin errors++; $display("FAIL rand%0d_dline got %h want %h", it, drd_line, exp_line(da)); end
            end
            if (ir) begin
                checks++; if (bus.icache_rd_data !== exp_line(ia)) begin errors++; $display("FAIL rand%0d_iline_hold got %h want %h", it, bus.icache_rd_data, exp_line(ia)); end
            end
        end
    endtask

    task automatic test_async_reset();
        bit to;
        int n;
        logic [31:0] da;
        beats.delete();
        stall_max = 0;
        @(posedge clk); #2;
        bus.dcache_rd_addr = 32'h0000_4A40;
        bus.dcache_rd_req  = 1'b1;
        n = 0;
        while (beats.size() < 2 && n < 50) begin @(posedge clk); n++; end
        checks++; if (n >= 50) begin errors++; $display("FAIL arst_start got no beats want 2"); end
        #3 rst = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL arst_bus got %b/%h/%b want 0/0/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        checks++; if (bus.dcache_rd_data !== 128'h0 || bus.icache_rd_data !== 128'h0 || bus.dcache_rd_ready !== 1'b0) begin errors++; $display("FAIL arst_lines got %h/%h want 0", bus.dcache_rd_data, bus.icache_rd_data); end
        bus.dcache_rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        da = $urandom;
        build_model(0, 1, 0, 0, da, 0, 0);
        run_scn(0, 1, 0, 0, da, 0, 0, 2, -1, to);
        checks++; if (to || beats.size() != BEATS) begin errors++; $display("FAIL arst_rerun_nbeats got %0d to=%b want %0d", beats.size(), to, BEATS); end
        if (beats.size() > 0) begin
            checks++; if (beats[0].addr !== exp_beats[0].addr) begin errors++; $display("FAIL arst_rerun_first got %h want %h", beats[0].addr, exp_beats[0].addr); end
        end
        checks++; if (drd_line !== exp_line(da)) begin errors++; $display("FAIL arst_rerun_line got %h want %h", drd_line, exp_line(da)); end
    endtask

    task automatic test_i_drop();
        bit to;
        logic [31:0] ia;
        ia = $urandom;
        build_model(0, 0, 1, 0, 0, ia, 0);
        run_scn(0, 0, 1, 0, 0, ia, 0, 2, 2, to);
        checks++; if (to || beats.size() != BEATS) begin errors++; $display("FAIL idrop_nbeats got %0d to=%b want %0d", beats.size(), to, BEATS); end
        checks++; if (ird_cnt != 1) begin errors++; $display("FAIL idrop_pulses got %0d want 1", ird_cnt); end
        checks++; if (ird_line !== exp_line(ia)) begin errors++; $display("FAIL idrop_line got %h want %h", ird_line, exp_line(ia)); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL idrop_idle got %b want 0", bus.mem_req); end
    endtask

    initial begin
        bus.icache_rd_req = 1'b0; bus.icache_rd_addr = '0;
        bus.dcache_rd_req = 1'b0; bus.dcache_rd_addr = '0;
        bus.dcache_wr_req = 1'b0; bus.dcache_wr_addr = '0; bus.dcache_wr_data = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_i_refill();
        test_priority();
        test_eviction();
        test_random_stalls();
        test_async_reset();
        test_i_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got time limit reached want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
